// File: rtl/divider_sequencer_if.sv
// Request/result handshake bundle for divider_sequencer.
// master drives requests and accepts results; slave is the divider.
interface divider_sequencer_if #(
   parameter int DIVIDENDLEN = 16,
   parameter int DIVISORLEN  = 8
);
   logic                   in_valid;
   logic                   in_ready;
   logic [DIVIDENDLEN-1:0] dividend;
   logic [DIVISORLEN-1:0]  divisor;
   logic                   out_valid;
   logic                   out_ready;
   logic [DIVIDENDLEN-1:0] quotient;
   logic [DIVISORLEN-1:0]  remainder;
   logic                   div_by_zero;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/divider_sequencer.sv
// Restoring unsigned divider, one quotient bit per clock.
// IDLE accepts, ITER iterates, DONE holds the result until taken.
module divider_sequencer #(
   parameter int DIVIDENDLEN = 16,
   parameter int DIVISORLEN  = 8
) (
   input logic clk,
   input logic resetn,
   divider_sequencer_if.slave bus
);
   localparam int CW = $clog2(DIVIDENDLEN + 1);
   localparam logic [CW-1:0] C_LOAD = CW'(DIVIDENDLEN);
   localparam logic [CW-1:0] C_LAST = CW'(1);

   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

   state_t                 r_state;
   logic [DIVIDENDLEN-1:0] r_quo;
   logic [DIVISORLEN:0]    r_rem;
   logic [DIVISORLEN-1:0]  r_div;
   logic [CW-1:0]          r_cnt;
   logic                   r_dbz;
   logic                   r_in_ready;
   logic                   r_out_valid;

   logic [DIVISORLEN:0]    w_shift;
   logic [DIVISORLEN:0]    w_div_ext;
   logic [DIVISORLEN:0]    w_diff;
   logic                   w_ge;
   logic                   w_take;
   logic                   w_unused;

   // Partial remainder stays below the divisor, so its top bit is
   // always clear before the shift and only the low bits feed it.
   assign w_shift   = {r_rem[DIVISORLEN-1:0], r_quo[DIVIDENDLEN-1]};
   assign w_div_ext = {1'b0, r_div};
   assign w_ge      = (w_shift >= w_div_ext);
   assign w_diff    = w_shift - w_div_ext;
   assign w_take    = r_out_valid & bus.out_ready;
   assign w_unused  = r_rem[DIVISORLEN];

   assign bus.in_ready    = r_in_ready;
   assign bus.out_valid   = r_out_valid;
   assign bus.quotient    = r_quo;
   assign bus.remainder   = r_rem[DIVISORLEN-1:0];
   assign bus.div_by_zero = r_dbz;

   // Control FSM and datapath; out_valid trails entry into DONE by a cycle.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state     <= IDLE;
         r_quo       <= '0;
         r_rem       <= '0;
         r_div       <= '0;
         r_cnt       <= '0;
         r_dbz       <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_quo      <= bus.dividend;
                  r_div      <= bus.divisor;
                  r_rem      <= '0;
                  r_cnt      <= C_LOAD;
                  r_in_ready <= 1'b0;
                  if (bus.divisor == '0) begin
                     r_quo   <= '1;
                     r_dbz   <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     r_state <= ITER;
                  end
               end
            end
            ITER: begin
               r_rem <= w_ge ? w_diff : w_shift;
               r_quo <= {r_quo[DIVIDENDLEN-2:0], w_ge};
               r_cnt <= r_cnt - C_LAST;
               if (r_cnt == C_LAST) begin
                  r_state <= DONE;
               end
            end
            DONE: begin
               if (w_take) begin
                  r_state     <= IDLE;
                  r_dbz       <= 1'b0;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end else begin
                  r_out_valid <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_divider_sequencer.sv
// Directed and random checks of divider_sequencer against a
// queue of expected results built from integer / and %.
module tb_divider_sequencer;
   localparam int DL = 16;
   localparam int DV = 8;

   typedef struct {
      logic [DL-1:0] q;
      logic [DV-1:0] r;
      logic          z;
   } exp_t;

   logic clk = 1'b0;
   logic resetn;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   last_acc = -1000;
   int   acc;
   int   lat;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   divider_sequencer_if #(.DIVIDENDLEN(DL), .DIVISORLEN(DV)) bus ();

   divider_sequencer #(.DIVIDENDLEN(DL), .DIVISORLEN(DV)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.slave)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [DL-1:0] a, input logic [DV-1:0] b);
      exp_t e;
      if (b == 0) begin
         e.q = '1;
         e.r = '0;
         e.z = 1'b1;
      end else begin
         e.q = a / DL'(b);
         e.r = DV'(a % DL'(b));
         e.z = 1'b0;
      end
      sb.push_back(e);
   endtask

   // Present a request, wait for in_ready, and record the accepting cycle.
   task automatic request(input logic [DL-1:0] a, input logic [DV-1:0] b,
                          output int acc_cyc);
      int n;
      bus.dividend = a;
      bus.divisor  = b;
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 200) begin
         tick();
         n++;
      end
      if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
      tick();
      acc_cyc = cyc;
      push_exp(a, b);
      bus.in_valid = 1'b0;
      bus.dividend = DL'($urandom);
      bus.divisor  = DV'($urandom);
   endtask

   task automatic wait_valid(output int l);
      l = 0;
      while (!bus.out_valid && l < 200) begin
         tick();
         l++;
      end
      if (!bus.out_valid) chk("out_valid_timeout", 0, 1);
   endtask

   task automatic compare_head(input string tag);
      exp_t e;
      chk({tag, "_sb_nonempty"}, (sb.size() > 0), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_q"}, bus.quotient, e.q);
         chk({tag, "_r"}, bus.remainder, e.r);
         chk({tag, "_z"}, bus.div_by_zero, e.z);
      end
   endtask

   task automatic consume(input string tag);
      compare_head(tag);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk({tag, "_idle_rdy"}, bus.in_ready, 1);
      chk({tag, "_idle_ov"}, bus.out_valid, 0);
      chk({tag, "_idle_z"}, bus.div_by_zero, 0);
   endtask

   task automatic run_one(input string tag, input logic [DL-1:0] a,
                          input logic [DV-1:0] b, input int exp_lat);
      int a_c;
      int l;
      request(a, b, a_c);
      wait_valid(l);
      chk({tag, "_lat"}, l, exp_lat);
      consume(tag);
   endtask

   initial begin
      logic [DL-1:0] hq;
      logic [DV-1:0] hr;
      logic          hz;
      logic [DL-1:0] ra;
      logic [DV-1:0] rb;
      int            n;
      bit            done;

      resetn        = 1'b0;
      bus.in_valid  = 1'b1;
      bus.dividend  = 16'd77;
      bus.divisor   = 8'd3;
      bus.out_ready = 1'b0;
      tick();
      tick();
      tick();
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_q", bus.quotient, 0);
      chk("rst_r", bus.remainder, 0);
      chk("rst_z", bus.div_by_zero, 0);
      bus.in_valid = 1'b0;
      resetn = 1'b1;
      tick();
      chk("post_rst_ready", bus.in_ready, 1);

      run_one("basic", 16'd100, 8'd7, DL + 1);
      run_one("ext_max", 16'd65535, 8'd255, DL + 1);
      run_one("ext_small", 16'd5, 8'd9, DL + 1);
      run_one("zero_div", 16'd1234, 8'd0, 1);
      run_one("div_one", 16'hBEEF, 8'd1, DL + 1);

      request(16'd50000, 8'd13, acc);
      wait_valid(lat);
      chk("bp_lat", lat, DL + 1);
      hq = bus.quotient;
      hr = bus.remainder;
      hz = bus.div_by_zero;
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = ~bus.in_valid;
         bus.dividend = DL'($urandom);
         bus.divisor  = DV'($urandom);
         tick();
         chk("bp_q_hold", bus.quotient, hq);
         chk("bp_r_hold", bus.remainder, hr);
         chk("bp_z_hold", bus.div_by_zero, hz);
         chk("bp_in_ready", bus.in_ready, 0);
         chk("bp_out_valid", bus.out_valid, 1);
      end
      bus.in_valid = 1'b0;
      consume("bp");

      request(16'd100, 8'd7, acc);
      for (int i = 0; i < 7; i++) tick();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      void'(sb.pop_back());
      chk("abort_in_ready", bus.in_ready, 1);
      chk("abort_out_valid", bus.out_valid, 0);
      chk("abort_q", bus.quotient, 0);
      run_one("after_abort", 16'd200, 8'd3, DL + 1);

      last_acc = -1000;
      for (int k = 0; k < 500; k++) begin
         ra = DL'($urandom);
         rb = DV'($urandom_range(1, 255));
         if (k % 5 == 0) rb = DV'($urandom_range(1, 4));
         request(ra, rb, acc);
         chk("rnd_spacing_ok", ((acc - last_acc) >= DL + 2), 1);
         last_acc = acc;
         done = 1'b0;
         n = 0;
         while (!done && n < 400) begin
            bus.out_ready = ($urandom_range(0, 1) == 1);
            bus.in_valid  = ($urandom_range(0, 1) == 1);
            if (bus.out_valid && bus.out_ready) begin
               compare_head("rnd");
               done = 1'b1;
            end
            tick();
            n++;
         end
         bus.out_ready = 1'b0;
         bus.in_valid  = 1'b0;
         if (!done) chk("rnd_result_timeout", 0, 1);
      end

      chk("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
